// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: MEM stage on port 0,
// debug/DMA loader on port 1. Each access runs IDLE -> ACCESS -> DONE.
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              stall0,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              read,
    output logic              write,
    input  logic [DATA_W-1:0] read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state;
    logic   last_grant;
    logic   winner;
    logic   lat_we;
    logic   grant_sel;
    logic   sel_we;

    // On a tie, round-robin favours the port not served last; otherwise port 0.
    always_comb begin
        grant_sel = 1'b0;
        if (req0 && req1)
            grant_sel = (RR_EN != 0) ? ~last_grant : 1'b0;
        else
            grant_sel = req1;
        sel_we = grant_sel ? we1 : we0;
    end

    assign stall0 = req0 & ~ack0;

    // The memory pins double as the latched addr/wdata copy, so fields that
    // change after the grant edge cannot disturb the access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            winner     <= 1'b0;
            lat_we     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            address    <= '0;
            write_data <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        winner     <= grant_sel;
                        lat_we     <= sel_we;
                        address    <= grant_sel ? addr1 : addr0;
                        write_data <= grant_sel ? wdata1 : wdata0;
                        read       <= ~sel_we;
                        write      <= sel_we;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        if (winner)
                            rdata1 <= read_data;
                        else
                            rdata0 <= read_data;
                    end
                    last_grant <= winner;
                    ack0       <= ~winner;
                    ack1       <= winner;
                    address    <= '0;
                    write_data <= '0;
                    read       <= 1'b0;
                    write      <= 1'b0;
                    state      <= DONE;
                end
                // Requests are ignored here so a held req is not re-served.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: table-driven single accesses, hand-written tie,
// field-change and reset sequences, then random traffic against a slot model.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, stall0, read, write;
    logic [7:0] rdata0, rdata1, address, write_data, read_data;
    logic       f_ack0, f_ack1, f_stall0, f_read, f_write;
    logic [7:0] f_rdata0, f_rdata1, f_address, f_write_data, f_read_data;

    logic [7:0] mem   [256];
    logic [7:0] mem_f [256];
    logic [7:0] ref_mem [256];

    int checks = 0;
    int errors = 0;

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .stall0(stall0),
        .address(address), .write_data(write_data), .read(read), .write(write),
        .read_data(read_data)
    );

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(f_ack0), .ack1(f_ack1), .rdata0(f_rdata0), .rdata1(f_rdata1), .stall0(f_stall0),
        .address(f_address), .write_data(f_write_data), .read(f_read), .write(f_write),
        .read_data(f_read_data)
    );

    assign read_data   = mem[address];
    assign f_read_data = mem_f[f_address];

    always @(posedge clk) begin
        if (write)   mem[address]     <= write_data;
        if (f_write) mem_f[f_address] <= f_write_data;
    end

    function automatic logic [7:0] init_val(input int a);
        if (a == 101) return 8'h7F;
        if (a == 102) return 8'h81;
        if (a == 103) return 8'h22;
        return 8'((a * 7 + 3) & 255);
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit p, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        if (!p) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else    begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    // One access on one port: grant edge, access cycle, ack cycle.
    task automatic do_single(input vec_t v);
        @(negedge clk);
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk1("acc_write", write, v.we);
        chk1("acc_read", read, !v.we);
        chk8("acc_addr", address, v.addr);
        if (v.we) chk8("acc_wdata", write_data, v.wdata);
        chk1("acc_no_early_ack", ack0 | ack1, 1'b0);
        @(negedge clk);
        chk1("ack_winner", v.port ? ack1 : ack0, 1'b1);
        chk1("ack_other", v.port ? ack0 : ack1, 1'b0);
        chk8("rdata", v.port ? rdata1 : rdata0, v.exp_rdata);
        drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Invariants that hold on every cycle outside reset.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk1("mon_ack_excl", ack0 & ack1, 1'b0);
            chk1("mon_rw_excl", read & write, 1'b0);
            chk1("mon_stall0", stall0, req0 & ~ack0);
            chk1("mon_f_stall0", f_stall0, req0 & ~f_ack0);
        end
    end

    vec_t tbl [10];

    int         free_at, pend_p, pend_at, last_w;
    bit         act [2];
    bit         op_w [2];
    logic [7:0] op_a [2];
    logic [7:0] op_d [2];
    logic [7:0] exp_rd [2];
    bit         g_w;
    logic [7:0] g_a, g_d;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'd100, 8'h5A, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 8'd100, 8'h00, 8'h5A};
        tbl[2] = '{1'b1, 1'b0, 8'd101, 8'h00, 8'h7F};
        tbl[3] = '{1'b1, 1'b1, 8'd200, 8'h33, 8'h7F};
        tbl[4] = '{1'b1, 1'b0, 8'd200, 8'h00, 8'h33};
        tbl[5] = '{1'b0, 1'b1, 8'd0,   8'hC3, 8'h5A};
        tbl[6] = '{1'b0, 1'b0, 8'd0,   8'h00, 8'hC3};
        tbl[7] = '{1'b1, 1'b1, 8'd255, 8'hEE, 8'h33};
        tbl[8] = '{1'b1, 1'b0, 8'd255, 8'h00, 8'hEE};
        tbl[9] = '{1'b0, 1'b0, 8'd255, 8'h00, 8'hEE};

        for (int i = 0; i < 256; i++) begin
            mem[i]     <= init_val(i);
            mem_f[i]   <= init_val(i);
            ref_mem[i] = init_val(i);
        end

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk1("rst_ack0", ack0, 1'b0);
        chk1("rst_ack1", ack1, 1'b0);
        chk1("rst_read", read, 1'b0);
        chk1("rst_write", write, 1'b0);
        chk1("rst_stall0", stall0, 1'b0);
        chk8("rst_rdata0", rdata0, 8'h00);
        chk8("rst_rdata1", rdata1, 8'h00);
        chk8("rst_address", address, 8'h00);
        chk8("rst_wdata", write_data, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) do_single(tbl[i]);

        // Field change during ACCESS must not affect the latched address
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'd102, 8'h00);
        @(negedge clk);
        chk8("chg_addr_latched", address, 8'd102);
        addr0 = 8'd103;
        @(negedge clk);
        chk1("chg_ack0", ack0, 1'b1);
        chk8("chg_rdata0", rdata0, 8'h81);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset during the ACCESS cycle of a write aborts it
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'd100, 8'hFF);
        @(negedge clk);
        chk1("rstacc_write_before", write, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rstacc_write_now", write, 1'b0);
        chk8("rstacc_addr_now", address, 8'h00);
        req0 = 1'b0;
        @(negedge clk);
        chk1("rstacc_no_ack0", ack0, 1'b0);
        chk8("rstacc_rdata0", rdata0, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk1("rstacc_no_ack0_after", ack0, 1'b0);
        do_single('{1'b0, 1'b0, 8'd100, 8'h00, 8'h5A});

        // Both requests held: round-robin alternates, fixed priority starves port 1
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'd101, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'd102, 8'h00);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk1("tie_rr_ack0", ack0, j == 2 || j == 8);
            chk1("tie_rr_ack1", ack1, j == 5 || j == 11);
            chk1("tie_fp_ack0", f_ack0, (j % 3) == 2);
            chk1("tie_fp_ack1", f_ack1, 1'b0);
            chk1("tie_rr_stall0", stall0, !(j == 2 || j == 8));
            if (j == 12) begin req0 = 1'b0; req1 = 1'b0; end
        end
        chk8("tie_rr_rdata0", rdata0, 8'h7F);
        chk8("tie_rr_rdata1", rdata1, 8'h81);
        chk8("tie_fp_rdata1", f_rdata1, 8'h00);

        // Fixed priority: port 1 served once port 0 drops its request
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'd101, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'd103, 8'h00);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            chk1("fp_ack0", f_ack0, j == 2);
            chk1("fp_ack1", f_ack1, j == 5);
            chk1("fp_rr_ack1", ack1, j == 5);
            if (j == 2) req0 = 1'b0;
            if (j == 5) req1 = 1'b0;
        end
        chk8("fp_rdata1", f_rdata1, 8'h22);

        // Random traffic against a transaction-level model: the arbiter samples
        // requests when free, acks two cycles after the grant, then is free
        // again one cycle after the ack.
        do_reset();
        free_at = 0; pend_p = -1; pend_at = -1; last_w = 1;
        act[0] = 1'b0; act[1] = 1'b0;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        g_w = 1'b0; g_a = 8'h00; g_d = 8'h00;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            chk1("rnd_ack0", ack0, pend_p == 0 && pend_at == n);
            chk1("rnd_ack1", ack1, pend_p == 1 && pend_at == n);
            if (pend_p >= 0 && pend_at == n + 1) begin
                chk1("rnd_write", write, g_w);
                chk1("rnd_read", read, !g_w);
                chk8("rnd_addr", address, g_a);
                if (g_w) chk8("rnd_wdata", write_data, g_d);
            end
            if (pend_p >= 0 && pend_at == n) begin
                if (g_w) ref_mem[g_a] = g_d;
                else     exp_rd[pend_p] = ref_mem[g_a];
                last_w = pend_p;
                act[pend_p] = 1'b0;
                pend_p = -1;
            end
            chk8("rnd_rdata0", rdata0, exp_rd[0]);
            chk8("rnd_rdata1", rdata1, exp_rd[1]);
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && n < 480 && $urandom_range(0, 1) == 1) begin
                    act[p]  = 1'b1;
                    op_w[p] = 1'($urandom_range(0, 1));
                    op_a[p] = 8'($urandom_range(16, 47));
                    op_d[p] = 8'($urandom);
                end
                if (act[p] && pend_p == p)
                    drive(1'(p), 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                else
                    drive(1'(p), act[p], op_w[p], op_a[p], op_d[p]);
            end
            if (n >= free_at && (act[0] || act[1])) begin
                pend_p  = (act[0] && act[1]) ? 1 - last_w : (act[1] ? 1 : 0);
                pend_at = n + 2;
                free_at = n + 3;
                g_w = op_w[pend_p];
                g_a = op_a[pend_p];
                g_d = op_d[pend_p];
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
